// File: rtl/range_finder_trigger_pio.sv
// Avalon-MM output PIO: static level register plus a hardware-timed one-shot pulse.
// Define RANGE_FINDER_TRIGGER_PIO_READBACK_EN to build the registered read mux.
//
// state | meaning
// IDLE  | no pulse; PULSE_MASK not driven onto out_port
// RUN   | pulse active; cnt holds cycles remaining including the current one
module range_finder_trigger_pio #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] DATA_RESET = '0,
  parameter logic [15:0]      PW_RESET   = 16'd500
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [15:0]      pw_q, pw_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             wr;
  logic             busy;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign busy         = (state_q == RUN);
  assign unused_wdata = ^writedata[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= DATA_RESET;
      mask_q  <= '0;
      pw_q    <= PW_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;

    if (wr && address == 2'd0) data_d = writedata[WIDTH-1:0];
    if (wr && address == 2'd1) pw_d   = writedata[15:0];

    case (state_q)
      IDLE: begin
        // Zero width or empty mask would make a pulse with no visible effect
        if (wr && address == 2'd2 && pw_q != 16'd0 && writedata[WIDTH-1:0] != '0) begin
          state_d = RUN;
          cnt_d   = pw_q;
          mask_d  = writedata[WIDTH-1:0];
        end
      end
      RUN: begin
        if ((wr && address == 2'd3) || cnt_q == 16'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign out_port = data_q | (busy ? mask_q : '0);

`ifdef RANGE_FINDER_TRIGGER_PIO_READBACK_EN
  logic [31:0] rd_q, rd_d;

  always_comb begin
    rd_d = '0;
    case (address)
      2'd0: rd_d[WIDTH-1:0] = data_q;
      2'd1: rd_d[15:0]      = pw_q;
      2'd2: begin
        rd_d[WIDTH-1:0] = mask_q;
        rd_d[31]        = busy;
      end
      default: rd_d[15:0] = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_q <= '0;
    else          rd_q <= rd_d;
  end

  assign readdata = rd_q;
`else
  assign readdata = '0;
`endif

endmodule

// File: tb/tb_range_finder_trigger_pio.sv
// Bench for range_finder_trigger_pio: timestamp-based pulse model checked every cycle,
// plus directed pulse-length, retrigger, abort and asynchronous reset checks.
module tb_range_finder_trigger_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int total = 0;
  int bad   = 0;

  range_finder_trigger_pio #(.WIDTH(8), .DATA_RESET(8'h00), .PW_RESET(16'd500)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pulse is the half-open cycle interval [start, pend); busy while cyc < pend.
  int          cyc  = 0;
  int          pend = 0;
  logic [7:0]  m_data = 8'h00;
  logic [7:0]  m_mask = 8'h00;
  logic [15:0] m_pw   = 16'd500;
  logic [31:0] exp_rd = 32'd0;
  bit          model_live = 0;

  initial begin
    bit busy_pre;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_data = 8'h00; m_pw = 16'd500; m_mask = 8'h00;
        pend = cyc; exp_rd = 32'd0; model_live = 1;
      end else if (model_live) begin
        busy_pre = (cyc < pend);
`ifdef RANGE_FINDER_TRIGGER_PIO_READBACK_EN
        case (address)
          2'd0: exp_rd = {24'd0, m_data};
          2'd1: exp_rd = {16'd0, m_pw};
          2'd2: exp_rd = {busy_pre, 23'd0, m_mask};
          default: exp_rd = busy_pre ? 32'(pend - cyc) : 32'd0;
        endcase
`else
        exp_rd = 32'd0;
`endif
        cyc++;
        if (chipselect && !write_n) begin
          case (address)
            2'd0: m_data = writedata[7:0];
            2'd1: m_pw   = writedata[15:0];
            2'd2: if (!busy_pre && m_pw != 0 && writedata[7:0] != 0) begin
                    m_mask = writedata[7:0];
                    pend   = cyc + int'(m_pw);
                  end
            default: if (busy_pre) pend = cyc;
          endcase
        end
      end
      #1;
      if (model_live) begin
        chk("out_port", {24'd0, out_port}, {24'd0, m_data | ((cyc < pend) ? m_mask : 8'h00)});
        chk("readdata", readdata, exp_rd);
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wait_low(input int bitn, output int t);
    int n = 0;
    while (out_port[bitn] === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("wait_low_timeout", 32'(n), 32'd0);
    t = cyc;
  endtask

  initial begin
    int t0, t1;
    repeat (3) @(negedge clk);
    chk("reset_out_port", {24'd0, out_port}, 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    address = 2'd1;
    @(negedge clk);
    @(negedge clk);
`ifdef RANGE_FINDER_TRIGGER_PIO_READBACK_EN
    chk("reset_pw_read", readdata, 32'h1F4);
`endif

    wr(2'd0, 32'hA5);
    chk("data_a5", {24'd0, out_port}, 32'hA5);
    @(negedge clk);
`ifdef RANGE_FINDER_TRIGGER_PIO_READBACK_EN
    chk("data_a5_read", readdata, 32'hA5);
`endif

    wr(2'd1, 32'd10);
    wr(2'd0, 32'd0);
    wr(2'd2, 32'h01);
    t0 = cyc;
    address = 2'd3;
    wait_low(0, t1);
    chk("pulse10_len", 32'(t1 - t0), 32'd10);

    wr(2'd1, 32'd100);
    wr(2'd2, 32'h01);
    t0 = cyc;
    repeat (48) @(negedge clk);
    wr(2'd2, 32'hFF);
    chk("retrigger_mask_kept", {24'd0, out_port}, 32'h01);
    wait_low(0, t1);
    chk("pulse100_len", 32'(t1 - t0), 32'd100);

    wr(2'd2, 32'h01);
    t0 = cyc;
    repeat (58) @(negedge clk);
    wr(2'd3, 32'd0);
    t1 = cyc;
    chk("abort_low", {24'd0, out_port}, 32'h0);
    chk("abort_len", 32'(t1 - t0), 32'd60);
    repeat (3) @(negedge clk);

    wr(2'd1, 32'd0);
    wr(2'd2, 32'hFF);
    address = 2'd2;
    repeat (20) @(negedge clk);
    chk("pw0_no_pulse", {24'd0, out_port}, 32'h0);

    wr(2'd0, 32'h3C);
    wr(2'd1, 32'd200);
    wr(2'd2, 32'h81);
    repeat (20) @(negedge clk);
    chk("pulse_mid_or", {24'd0, out_port}, 32'hBD);
    #3 reset_n = 1'b0;
    #1 chk("async_reset_out", {24'd0, out_port}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wr(2'd1, 32'd5);
    wr(2'd2, 32'h02);
    t0 = cyc;
    wait_low(1, t1);
    chk("post_reset_len", 32'(t1 - t0), 32'd5);

    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 9);
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      if (r < 4) begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
      end else if (r == 4) begin
        chipselect = 1'b0; write_n = 1'b0;
      end else begin
        chipselect = 1'b1; write_n = 1'b0;
        if (address == 2'd1) writedata = 32'($urandom_range(0, 40));
        if (address == 2'd2 && $urandom_range(0, 7) == 0) writedata[7:0] = 8'h00;
        if (address == 2'd3 && $urandom_range(0, 3) != 0) address = 2'($urandom_range(0, 2));
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    repeat (50) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
